// File: rtl/rr_mux_4to1.sv
// rr_mux_4to1 - four-to-one valid/ready packet merger with round-robin
// arbitration and packet-level locking. It is the gather-side partner of
// demux_1to4: out_sel carries the 2-bit source index with the same encoding
// so that beats can be routed back.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   per-channel valid, bit i = channel i
//   in_data    channel i payload at [i*DATA_WIDTH +: DATA_WIDTH]
//   in_last    per-channel end-of-packet marker
//   in_ready   per-channel accept, one-hot or zero
//   out_valid  registered output beat valid
//   out_data   registered output payload
//   out_last   registered output end-of-packet marker
//   out_sel    source channel of the current output beat
//   out_ready  downstream accept
//   locked     high while a multi-beat packet holds the grant

// Per-channel slice: decides whether this lane is the current candidate
// and gates its payload onto the shared OR-reduction.
module rr_mux_lane #(
  parameter int         DATA_WIDTH = 8,
  parameter logic [1:0] LANE       = 2'd0
) (
  input  logic                  grant_en,
  input  logic                  cand_vld,
  input  logic [1:0]            cand_idx,
  input  logic [DATA_WIDTH-1:0] lane_data,
  input  logic                  lane_last,
  output logic                  lane_ready,
  output logic [DATA_WIDTH-1:0] pick_data,
  output logic                  pick_last
);
  logic hit;

  // A candidate only ever exists where in_valid is set, so hit implies valid.
  assign hit        = cand_vld && (cand_idx == LANE);
  assign lane_ready = grant_en && hit;
  assign pick_data  = hit ? lane_data : '0;
  assign pick_last  = hit && lane_last;
endmodule

module rr_mux_4to1 #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [3:0]              in_valid,
  input  logic [4*DATA_WIDTH-1:0] in_data,
  input  logic [3:0]              in_last,
  output logic [3:0]              in_ready,
  output logic                    out_valid,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic                    out_last,
  output logic [1:0]              out_sel,
  input  logic                    out_ready,
  output logic                    locked
);
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [1:0]              rr_ptr_q, rr_ptr_d;
  logic [1:0]              lock_sel_q, lock_sel_d;
  logic                    out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
  logic                    out_last_q, out_last_d;
  logic [1:0]              out_sel_q, out_sel_d;

  logic                    load_en;
  logic                    grant_en;
  logic                    cand_vld;
  logic [1:0]              cand_idx;
  logic [1:0]              scan_idx;
  logic                    xfer;
  logic [DATA_WIDTH-1:0]   win_data;
  logic                    win_last;

  logic [3:0][DATA_WIDTH-1:0] pick_data;
  logic [3:0]                 pick_last;

  // The output register can take a new beat when empty or draining this cycle.
  assign load_en  = !out_valid_q || out_ready;
  assign grant_en = rst_n && load_en;

  // Candidate selection. In IDLE scan from rr_ptr upward with wrap; scanning
  // offsets high-to-low lets the lowest offset overwrite and win. In LOCKED
  // only the owning channel is considered, so nobody can pre-empt a packet.
  always_comb begin
    cand_vld = 1'b0;
    cand_idx = rr_ptr_q;
    scan_idx = rr_ptr_q;
    if (state_q == ST_LOCKED) begin
      cand_vld = in_valid[lock_sel_q];
      cand_idx = lock_sel_q;
    end else begin
      for (int k = 3; k >= 0; k--) begin
        scan_idx = rr_ptr_q + 2'(k);
        if (in_valid[scan_idx]) begin
          cand_vld = 1'b1;
          cand_idx = scan_idx;
        end
      end
    end
  end

  for (genvar i = 0; i < 4; i++) begin : g_lane
    rr_mux_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .LANE       (2'(i))
    ) u_lane (
      .grant_en   (grant_en),
      .cand_vld   (cand_vld),
      .cand_idx   (cand_idx),
      .lane_data  (in_data[i*DATA_WIDTH +: DATA_WIDTH]),
      .lane_last  (in_last[i]),
      .lane_ready (in_ready[i]),
      .pick_data  (pick_data[i]),
      .pick_last  (pick_last[i])
    );
  end

  // At most one lane contributes, so an OR-reduction is the winner mux.
  always_comb begin
    win_data = '0;
    for (int i = 0; i < 4; i++) begin
      win_data = win_data | pick_data[i];
    end
  end

  assign win_last = |pick_last;
  assign xfer     = |in_ready;

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    lock_sel_d  = lock_sel_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_sel_d   = out_sel_q;
    if (xfer) begin
      // Load and drain may coincide: no bubble between beats.
      out_valid_d = 1'b1;
      out_data_d  = win_data;
      out_last_d  = win_last;
      out_sel_d   = cand_idx;
      if (win_last) begin
        state_d  = ST_IDLE;
        rr_ptr_d = cand_idx + 2'd1;
      end else begin
        state_d    = ST_LOCKED;
        lock_sel_d = cand_idx;
      end
    end else if (out_valid_q && out_ready) begin
      // Payload fields hold their last value once drained.
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= 2'd0;
      lock_sel_q  <= 2'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_sel_q   <= 2'd0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      lock_sel_q  <= lock_sel_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_sel_q   <= out_sel_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_sel   = out_sel_q;
  assign locked    = (state_q == ST_LOCKED);
endmodule

// File: tb/tb_rr_mux_4to1.sv
// Directed bench for rr_mux_4to1. Sources are per-channel beat queues that
// present their head beat until accepted; expected output beats are pushed
// into a scoreboard queue as stimulus is issued and a monitor compares them
// on every output transfer.
module tb_rr_mux_4to1;
  localparam int DW = 8;

  typedef logic [DW:0] beat_t;  // {last, data}
  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
    logic [1:0]    s;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic [3:0]    in_valid;
  logic [4*DW-1:0] in_data;
  logic [3:0]    in_last;
  logic [3:0]    in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic [1:0]    out_sel;
  logic          out_ready;
  logic          locked;

  beat_t sq [4][$];
  exp_t  exp_q [$];
  logic [3:0] hold;
  logic [3:0] acc;
  int errors = 0;
  int checks = 0;

  rr_mux_4to1 #(.DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_sel   (out_sel),
    .out_ready (out_ready),
    .locked    (locked)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int ch, input logic [DW-1:0] d, input logic l);
    exp_t e;
    sq[ch].push_back({l, d});
    e.d = d; e.l = l; e.s = 2'(ch);
    exp_q.push_back(e);
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      if (sq[i].size() > 0) begin
        in_valid[i] = !hold[i];
        in_data[i*DW +: DW] = sq[i][0][DW-1:0];
        in_last[i] = sq[i][0][DW];
      end else begin
        in_valid[i] = 1'b0;
        in_data[i*DW +: DW] = '0;
        in_last[i] = 1'b0;
      end
    end
    #1;
  endtask

  task automatic step();
    @(negedge clk);
    acc = in_valid & in_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (acc[i]) void'(sq[i].pop_front());
    end
    drive();
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || sq[0].size() != 0 || sq[1].size() != 0 ||
            sq[2].size() != 0 || sq[3].size() != 0) && n < 60) begin
      step();
      n++;
    end
    chk({name, "_drain_left"}, exp_q.size(), 0);
  endtask

  // Scoreboard monitor: every output transfer must match the queue head.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      exp_t e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_beat: got data=%0h last=%0b sel=%0d, expected none",
                 out_data, out_last, out_sel);
      end else begin
        e = exp_q.pop_front();
        if (out_data !== e.d || out_last !== e.l || out_sel !== e.s) begin
          errors++;
          $display("FAIL beat: got data=%0h last=%0b sel=%0d expected data=%0h last=%0b sel=%0d",
                   out_data, out_last, out_sel, e.d, e.l, e.s);
        end
      end
    end
  end

  initial begin
    logic [1:0] sel_seq [5];
    logic [7:0] dat_seq [5];
    sel_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    dat_seq = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA0};

    // Reset: in_ready must be zero combinationally even with all valid.
    hold = 4'b0000;
    rst_n = 1'b0;
    out_ready = 1'b1;
    in_valid = 4'b1111;
    in_data = '0;
    in_last = 4'b1111;
    #1;
    chk("reset_in_ready", in_ready, 4'b0000);
    drive();
    step();
    step();
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_data", out_data, 0);
    chk("reset_out_last", out_last, 0);
    chk("reset_out_sel", out_sel, 0);
    chk("reset_locked", locked, 0);
    rst_n = 1'b1;
    drive();

    // 1: all channels single-beat, round robin 0,1,2,3,0 back to back.
    push(0, 8'hA0, 1'b1); push(1, 8'hA1, 1'b1);
    push(2, 8'hA2, 1'b1); push(3, 8'hA3, 1'b1);
    push(0, 8'hA0, 1'b1);
    drive();
    chk("t1_first_ready", in_ready, 4'b0001);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("t1_valid", out_valid, 1);
      chk("t1_sel", out_sel, sel_seq[k]);
      chk("t1_data", out_data, dat_seq[k]);
    end
    drain("t1");

    // 2: ch1 three-beat packet holds the grant against ch2.
    push(1, 8'h11, 1'b0); push(1, 8'h12, 1'b0); push(1, 8'h13, 1'b1);
    push(2, 8'h22, 1'b1);
    drive();
    chk("t2_ready0", in_ready, 4'b0010);
    step();
    chk("t2_locked1", locked, 1);
    chk("t2_ready1", in_ready, 4'b0010);
    step();
    chk("t2_locked2", locked, 1);
    chk("t2_ready2", in_ready, 4'b0010);
    step();
    chk("t2_unlocked", locked, 0);
    chk("t2_ready3", in_ready, 4'b0100);
    step();
    chk("t2_sel_ch2", out_sel, 2);
    drain("t2");

    // 3: output backpressure keeps the beat stable and blocks all inputs.
    push(0, 8'h5A, 1'b1); push(0, 8'h5B, 1'b1);
    out_ready = 1'b0;
    drive();
    chk("t3_ready_empty", in_ready, 4'b0001);
    step();
    for (int k = 0; k < 3; k++) begin
      chk("t3_bp_data", out_data, 8'h5A);
      chk("t3_bp_sel", out_sel, 0);
      chk("t3_bp_last", out_last, 1);
      chk("t3_bp_ready", in_ready, 4'b0000);
      step();
    end
    chk("t3_bp_valid", out_valid, 1);
    out_ready = 1'b1;
    drive();
    chk("t3_release_ready", in_ready, 4'b0001);
    step();
    chk("t3_next_data", out_data, 8'h5B);
    drain("t3");
    // Single beat on ch2 leaves rr_ptr at 3.
    push(2, 8'h52, 1'b1);
    drive();
    drain("t3b");

    // 4: wrap from ptr 3 with valid 1001, then ch0 alone at full rate.
    push(3, 8'h33, 1'b1); push(0, 8'h30, 1'b1);
    drive();
    chk("t4_ready_wrap", in_ready, 4'b1000);
    step();
    chk("t4_sel3", out_sel, 3);
    chk("t4_ready_ch0", in_ready, 4'b0001);
    step();
    chk("t4_sel0", out_sel, 0);
    push(0, 8'h01, 1'b1); push(0, 8'h02, 1'b1); push(0, 8'h03, 1'b1);
    drive();
    for (int k = 0; k < 3; k++) begin
      chk("t4_rate_ready", in_ready, 4'b0001);
      step();
      chk("t4_rate_valid", out_valid, 1);
      chk("t4_rate_data", out_data, 32'(k + 1));
    end
    drain("t4");

    // 5: locked owner stalls; ch3 must not be granted mid-packet.
    push(0, 8'h40, 1'b0);
    drive();
    step();
    chk("t5_locked", locked, 1);
    hold[0] = 1'b1;
    push(0, 8'h41, 1'b1);
    // ch0's second beat was queued after its first, but its expected entry
    // must precede ch3's in the scoreboard.
    push(3, 8'h43, 1'b1);
    drive();
    chk("t5_stall_ready0", in_ready, 4'b0000);
    step();
    chk("t5_stall_valid1", out_valid, 0);
    chk("t5_stall_ready1", in_ready, 4'b0000);
    chk("t5_stall_locked1", locked, 1);
    step();
    chk("t5_stall_valid2", out_valid, 0);
    chk("t5_stall_ready2", in_ready, 4'b0000);
    hold[0] = 1'b0;
    drive();
    chk("t5_resume_ready", in_ready, 4'b0001);
    step();
    chk("t5_done_locked", locked, 0);
    chk("t5_ch3_ready", in_ready, 4'b1000);
    step();
    chk("t5_sel3", out_sel, 3);
    drain("t5");

    // 6: reset while ch2 owns the grant with a buffered beat.
    sq[2].push_back({1'b0, 8'h60});
    sq[2].push_back({1'b0, 8'h61});
    drive();
    step();
    chk("t6_locked", locked, 1);
    chk("t6_valid", out_valid, 1);
    rst_n = 1'b0;
    drive();
    chk("t6_rst_ready", in_ready, 4'b0000);
    step();
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_locked", locked, 0);
    chk("t6_rst_sel", out_sel, 0);
    sq[2].delete();
    rst_n = 1'b1;
    push(0, 8'h70, 1'b1); push(1, 8'h71, 1'b1);
    push(2, 8'h72, 1'b1); push(3, 8'h73, 1'b1);
    drive();
    chk("t6_first_ready", in_ready, 4'b0001);
    drain("t6");

    repeat (2) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
